// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg: shared SVGA 800x600@60 timing constants and position type
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package vga_pkg;

  localparam int POS_W = 11;

  localparam int HOR_TOTAL_DEF       = 1056;
  localparam int HOR_BLANK_START_DEF = 800;
  localparam int HOR_SYNC_START_DEF  = 840;
  localparam int HOR_SYNC_STOP_DEF   = 968;

  localparam int VER_TOTAL_DEF       = 628;
  localparam int VER_BLANK_START_DEF = 600;
  localparam int VER_SYNC_START_DEF  = 601;
  localparam int VER_SYNC_STOP_DEF   = 605;

  typedef logic [POS_W-1:0] vga_pos_t;

  function automatic bit axis_params_ok(input int total, input int blank_start,
                                        input int sync_start, input int sync_stop);
    return (sync_start > blank_start) && (sync_stop > sync_start) &&
           (total >= sync_stop) && (total <= 2048);
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_axis.sv
// ---------------------------------------------------------------------------
// vga_axis: one raster axis - wrapping counter with registered sync/blank decode
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module vga_axis
  import vga_pkg::*;
#(
  parameter int TOTAL       = HOR_TOTAL_DEF,
  parameter int BLANK_START = HOR_BLANK_START_DEF,
  parameter int SYNC_START  = HOR_SYNC_START_DEF,
  parameter int SYNC_STOP   = HOR_SYNC_STOP_DEF
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     advance,
  output vga_pos_t count,
  output logic     sync,
  output logic     blank,
  output logic     wrap
);

  localparam vga_pos_t LAST = vga_pos_t'(TOTAL - 1);

  generate
    if (!axis_params_ok(TOTAL, BLANK_START, SYNC_START, SYNC_STOP)) begin : g_param_check
      $error("vga_axis: illegal timing parameters");
    end
  endgenerate

  vga_pos_t count_next;

  assign wrap = advance && (count == LAST);

  always_comb begin
    count_next = count;
    if (wrap)
      count_next = '0;
    else if (advance)
      count_next = count + 1'b1;
  end

  // Flags decode the next count so they land in the same cycle as that count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
      sync  <= 1'b0;
      blank <= 1'b0;
    end else begin
      count <= count_next;
      sync  <= (int'(count_next) >= SYNC_START) && (int'(count_next) < SYNC_STOP);
      blank <= int'(count_next) >= BLANK_START;
    end
  end

endmodule

`default_nettype wire

// File: rtl/vga_timing.sv
// ---------------------------------------------------------------------------
// vga_timing: free-running 800x600@60 raster timing generator; defining
// VGA_FRAME_CNT_EN adds the 16-bit completed-frame counter output frame_cnt.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module vga_timing
  import vga_pkg::*;
#(
  parameter int HOR_TOTAL_TIME  = HOR_TOTAL_DEF,
  parameter int HOR_BLANK_START = HOR_BLANK_START_DEF,
  parameter int HOR_SYNC_START  = HOR_SYNC_START_DEF,
  parameter int HOR_SYNC_STOP   = HOR_SYNC_STOP_DEF,
  parameter int VER_TOTAL_TIME  = VER_TOTAL_DEF,
  parameter int VER_BLANK_START = VER_BLANK_START_DEF,
  parameter int VER_SYNC_START  = VER_SYNC_START_DEF,
  parameter int VER_SYNC_STOP   = VER_SYNC_STOP_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  output vga_pos_t    hcount,
  output logic        hsync,
  output logic        hblnk,
  output vga_pos_t    vcount,
  output logic        vsync,
  output logic        vblnk,
  output logic        frame_start
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  logic h_wrap;
  logic v_wrap;

  vga_axis #(
    .TOTAL       (HOR_TOTAL_TIME),
    .BLANK_START (HOR_BLANK_START),
    .SYNC_START  (HOR_SYNC_START),
    .SYNC_STOP   (HOR_SYNC_STOP)
  ) u_h_axis (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (1'b1),
    .count   (hcount),
    .sync    (hsync),
    .blank   (hblnk),
    .wrap    (h_wrap)
  );

  vga_axis #(
    .TOTAL       (VER_TOTAL_TIME),
    .BLANK_START (VER_BLANK_START),
    .SYNC_START  (VER_SYNC_START),
    .SYNC_STOP   (VER_SYNC_STOP)
  ) u_v_axis (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (h_wrap),
    .count   (vcount),
    .sync    (vsync),
    .blank   (vblnk),
    .wrap    (v_wrap)
  );

  // v_wrap only fires on an H wrap, so it marks the next position being 0,0.
  always_ff @(posedge clk) begin
    if (!rst_n)
      frame_start <= 1'b1;
    else
      frame_start <= v_wrap;
  end

`ifdef VGA_FRAME_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      frame_cnt <= '0;
    else if (v_wrap)
      frame_cnt <= frame_cnt + 16'd1;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_vga_timing.sv
// ---------------------------------------------------------------------------
// tb_vga_timing: directed self-checking bench for vga_timing
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_vga_timing;
  import vga_pkg::*;

  // Reduced-height raster: full-width lines, 12 lines per frame, 4-line vsync.
  localparam int S_VT    = 12;
  localparam int S_VB    = 6;
  localparam int S_VS    = 7;
  localparam int S_VE    = 11;
  localparam int S_FRAME = 1056 * S_VT;

  logic clk;
  logic full_rst_n;
  logic small_rst_n;
  logic tiny_rst_n;

  vga_pos_t f_hcount, f_vcount, s_hcount, s_vcount;
  logic     f_hsync, f_hblnk, f_vsync, f_vblnk, f_frame_start;
  logic     s_hsync, s_hblnk, s_vsync, s_vblnk, s_frame_start;
`ifdef VGA_FRAME_CNT_EN
  logic [15:0] f_frame_cnt, s_frame_cnt, t_frame_cnt;
  vga_pos_t    t_hcount, t_vcount;
  logic        t_hsync, t_hblnk, t_vsync, t_vblnk, t_frame_start;
`endif

  int checks;
  int errors;

  vga_timing u_full (
    .clk         (clk),
    .rst_n       (full_rst_n),
    .hcount      (f_hcount),
    .hsync       (f_hsync),
    .hblnk       (f_hblnk),
    .vcount      (f_vcount),
    .vsync       (f_vsync),
    .vblnk       (f_vblnk),
    .frame_start (f_frame_start)
`ifdef VGA_FRAME_CNT_EN
    ,
    .frame_cnt   (f_frame_cnt)
`endif
  );

  vga_timing #(
    .VER_TOTAL_TIME  (S_VT),
    .VER_BLANK_START (S_VB),
    .VER_SYNC_START  (S_VS),
    .VER_SYNC_STOP   (S_VE)
  ) u_small (
    .clk         (clk),
    .rst_n       (small_rst_n),
    .hcount      (s_hcount),
    .hsync       (s_hsync),
    .hblnk       (s_hblnk),
    .vcount      (s_vcount),
    .vsync       (s_vsync),
    .vblnk       (s_vblnk),
    .frame_start (s_frame_start)
`ifdef VGA_FRAME_CNT_EN
    ,
    .frame_cnt   (s_frame_cnt)
`endif
  );

`ifdef VGA_FRAME_CNT_EN
  // 3x3 raster: 9 cycles per frame, used to reach the 16-bit counter wrap.
  vga_timing #(
    .HOR_TOTAL_TIME  (3),
    .HOR_BLANK_START (1),
    .HOR_SYNC_START  (2),
    .HOR_SYNC_STOP   (3),
    .VER_TOTAL_TIME  (3),
    .VER_BLANK_START (1),
    .VER_SYNC_START  (2),
    .VER_SYNC_STOP   (3)
  ) u_tiny (
    .clk         (clk),
    .rst_n       (tiny_rst_n),
    .hcount      (t_hcount),
    .hsync       (t_hsync),
    .hblnk       (t_hblnk),
    .vcount      (t_vcount),
    .vsync       (t_vsync),
    .vblnk       (t_vblnk),
    .frame_start (t_frame_start),
    .frame_cnt   (t_frame_cnt)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic restart_small();
    small_rst_n = 1'b0;
    @(posedge clk); #1;
    small_rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({f_hcount, f_vcount, f_hsync, f_hblnk, f_vsync, f_vblnk, f_frame_start} !== {22'd0, 5'b00001}) begin
        errors++;
        $display("FAIL reset_full cycle %0d: got h=%0d v=%0d hs=%b hb=%b vs=%b vb=%b fs=%b, want zeros with fs=1",
                 i, f_hcount, f_vcount, f_hsync, f_hblnk, f_vsync, f_vblnk, f_frame_start);
      end
      checks++;
      if ({s_hcount, s_vcount, s_hsync, s_hblnk, s_vsync, s_vblnk, s_frame_start} !== {22'd0, 5'b00001}) begin
        errors++;
        $display("FAIL reset_small cycle %0d: got h=%0d v=%0d fs=%b, want zeros with fs=1",
                 i, s_hcount, s_vcount, s_frame_start);
      end
`ifdef VGA_FRAME_CNT_EN
      checks++;
      if (f_frame_cnt !== 16'd0) begin
        errors++;
        $display("FAIL reset_frame_cnt: got %0d want 0", f_frame_cnt);
      end
`endif
    end
    full_rst_n  = 1'b1;
    small_rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (f_hcount !== 11'd1 || f_vcount !== 11'd0 || f_frame_start !== 1'b0) begin
      errors++;
      $display("FAIL release: got h=%0d v=%0d fs=%b, want h=1 v=0 fs=0", f_hcount, f_vcount, f_frame_start);
    end
  endtask

  task automatic test_line_timing();
    int eh, ev, hs_cnt, hb_cnt;
    logic [26:0] exp_v, act_v;
    eh = 1; ev = 0; hs_cnt = 0; hb_cnt = 0;
    for (int i = 0; i < 1057; i++) begin
      exp_v = {11'(eh), 11'(ev), (eh >= 840 && eh < 968), (eh >= 800), 1'b0, 1'b0, (eh == 0 && ev == 0)};
      act_v = {f_hcount, f_vcount, f_hsync, f_hblnk, f_vsync, f_vblnk, f_frame_start};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL line_timing at h=%0d v=%0d: got %h want %h", eh, ev, act_v, exp_v);
      end
      if (ev == 0 && f_hsync === 1'b1) hs_cnt++;
      if (ev == 0 && f_hblnk === 1'b1) hb_cnt++;
      @(posedge clk); #1;
      if (eh == 1055) begin eh = 0; ev++; end else eh++;
    end
    checks++;
    if (hs_cnt != 128) begin
      errors++;
      $display("FAIL hsync_width: got %0d want 128", hs_cnt);
    end
    checks++;
    if (hb_cnt != 256) begin
      errors++;
      $display("FAIL hblnk_width: got %0d want 256", hb_cnt);
    end
  endtask

  task automatic test_frame_timing();
    int eh, ev, fs_n, first_fs, gap, vs_cnt;
    logic [26:0] exp_v, act_v;
    restart_small();
    eh = 1; ev = 0; fs_n = 0; first_fs = 0; gap = 0; vs_cnt = 0;
    for (int i = 0; i < 2 * S_FRAME + 1; i++) begin
      exp_v = {11'(eh), 11'(ev), (eh >= 840 && eh < 968), (eh >= 800),
               (ev >= S_VS && ev < S_VE), (ev >= S_VB), (eh == 0 && ev == 0)};
      act_v = {s_hcount, s_vcount, s_hsync, s_hblnk, s_vsync, s_vblnk, s_frame_start};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL frame_timing at h=%0d v=%0d: got %h want %h", eh, ev, act_v, exp_v);
      end
      if (s_vsync === 1'b1) vs_cnt++;
      if (s_frame_start === 1'b1) begin
        fs_n++;
        if (fs_n == 1) first_fs = i;
        else if (fs_n == 2) gap = i - first_fs;
      end
      @(posedge clk); #1;
      if (eh == 1055) begin
        eh = 0;
        ev = (ev == S_VT - 1) ? 0 : ev + 1;
      end else begin
        eh++;
      end
    end
    checks++;
    if (fs_n != 2 || gap != S_FRAME) begin
      errors++;
      $display("FAIL frame_period: got %0d pulses gap %0d want 2 pulses gap %0d", fs_n, gap, S_FRAME);
    end
    checks++;
    if (vs_cnt != 2 * 4224) begin
      errors++;
      $display("FAIL vsync_width: got %0d want %0d", vs_cnt, 2 * 4224);
    end
  endtask

  task automatic test_frame_wrap();
    restart_small();
    repeat (11 * 1056 + 1054) @(posedge clk);
    #1;
    checks++;
    if ({s_hcount, s_vcount, s_hblnk, s_vblnk, s_frame_start} !== {11'd1055, 11'd11, 3'b110}) begin
      errors++;
      $display("FAIL pre_wrap: got h=%0d v=%0d hb=%b vb=%b fs=%b want 1055,11 hb=1 vb=1 fs=0",
               s_hcount, s_vcount, s_hblnk, s_vblnk, s_frame_start);
    end
    @(posedge clk); #1;
    checks++;
    if ({s_hcount, s_vcount, s_hsync, s_hblnk, s_vsync, s_vblnk, s_frame_start} !== {22'd0, 5'b00001}) begin
      errors++;
      $display("FAIL frame_wrap: got h=%0d v=%0d hb=%b vb=%b fs=%b want 0,0 hb=0 vb=0 fs=1",
               s_hcount, s_vcount, s_hblnk, s_vblnk, s_frame_start);
    end
`ifdef VGA_FRAME_CNT_EN
    checks++;
    if (s_frame_cnt !== 16'd1) begin
      errors++;
      $display("FAIL wrap_frame_cnt: got %0d want 1", s_frame_cnt);
    end
`endif
  endtask

  task automatic test_mid_frame_reset();
    restart_small();
    repeat (8 * 1056 + 99) @(posedge clk);
    #1;
    checks++;
    if (s_hcount !== 11'd100 || s_vcount !== 11'd8 || s_vsync !== 1'b1) begin
      errors++;
      $display("FAIL in_vsync: got h=%0d v=%0d vs=%b want 100,8 vs=1", s_hcount, s_vcount, s_vsync);
    end
    small_rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({s_hcount, s_vcount, s_hsync, s_hblnk, s_vsync, s_vblnk, s_frame_start} !== {22'd0, 5'b00001}) begin
      errors++;
      $display("FAIL mid_reset: got h=%0d v=%0d vs=%b vb=%b fs=%b want 0,0 vs=0 vb=0 fs=1",
               s_hcount, s_vcount, s_vsync, s_vblnk, s_frame_start);
    end
`ifdef VGA_FRAME_CNT_EN
    checks++;
    if (s_frame_cnt !== 16'd0) begin
      errors++;
      $display("FAIL mid_reset_frame_cnt: got %0d want 0", s_frame_cnt);
    end
`endif
    small_rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (s_hcount !== 11'd1 || s_vcount !== 11'd0 || s_vsync !== 1'b0 || s_frame_start !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_release: got h=%0d v=%0d vs=%b fs=%b want 1,0 vs=0 fs=0",
               s_hcount, s_vcount, s_vsync, s_frame_start);
    end
  endtask

`ifdef VGA_FRAME_CNT_EN
  task automatic test_frame_cnt();
    int seen;
    restart_small();
    seen = 0;
    for (int i = 0; i < 3 * S_FRAME + 10 && seen < 3; i++) begin
      @(posedge clk); #1;
      if (s_frame_start === 1'b1) begin
        seen++;
        checks++;
        if (s_frame_cnt !== 16'(seen)) begin
          errors++;
          $display("FAIL frame_cnt pulse %0d: got %0d want %0d", seen, s_frame_cnt, seen);
        end
      end
    end
    checks++;
    if (seen != 3) begin
      errors++;
      $display("FAIL frame_cnt_pulses: got %0d want 3 (cycle budget)", seen);
    end
  endtask

  task automatic test_frame_cnt_wrap();
    tiny_rst_n = 1'b0;
    @(posedge clk); #1;
    tiny_rst_n = 1'b1;
    @(posedge clk); #1;
    repeat (8 + 65534 * 9) @(posedge clk);
    #1;
    checks++;
    if (t_frame_start !== 1'b1 || t_frame_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL cnt_max: got fs=%b cnt=%0d want fs=1 cnt=65535", t_frame_start, t_frame_cnt);
    end
    repeat (9) @(posedge clk);
    #1;
    checks++;
    if (t_frame_start !== 1'b1 || t_frame_cnt !== 16'd0) begin
      errors++;
      $display("FAIL cnt_wrap: got fs=%b cnt=%0d want fs=1 cnt=0", t_frame_start, t_frame_cnt);
    end
  endtask
`endif

  initial begin
    full_rst_n  = 1'b0;
    small_rst_n = 1'b0;
    tiny_rst_n  = 1'b0;
    checks = 0;
    errors = 0;
    test_reset();
    test_line_timing();
    test_frame_timing();
    test_frame_wrap();
    test_mid_frame_reset();
`ifdef VGA_FRAME_CNT_EN
    test_frame_cnt();
    test_frame_cnt_wrap();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
